// File: rtl/multi_channel_pulse_source_if.sv
// multi_channel_pulse_source_if
//   Configuration inputs and pulse/count outputs of the multi-channel pulse
//   source, bundled as one interface.
//   master : control-register side (drives configuration, reads pulses/counts)
//   slave  : pulse source side
//   Signals: ena, mode, rate, pulse_width, dead_time, seed_load, cnt_clr (cfg)
//            pulse[N_CH], evt_count[N_CH*CNT_W] (status)
interface multi_channel_pulse_source_if #(
    parameter int N_CH   = 4,
    parameter int LFSR_W = 16,
    parameter int PW_W   = 4,
    parameter int DT_W   = 8,
    parameter int CNT_W  = 16
);
    logic                    ena;
    logic                    mode;
    logic [LFSR_W-1:0]       rate;
    logic [PW_W-1:0]         pulse_width;
    logic [DT_W-1:0]         dead_time;
    logic                    seed_load;
    logic                    cnt_clr;
    logic [N_CH-1:0]         pulse;
    logic [N_CH*CNT_W-1:0]   evt_count;

    modport master (
        output ena, mode, rate, pulse_width, dead_time, seed_load, cnt_clr,
        input  pulse, evt_count
    );

    modport slave (
        input  ena, mode, rate, pulse_width, dead_time, seed_load, cnt_clr,
        output pulse, evt_count
    );
endinterface

// File: rtl/multi_channel_pulse_source.sv
// multi_channel_pulse_source
//   N_CH independent pulse channels, each with its own LFSR, an
//   IDLE/HIGH/DEAD sequencer, and a saturating event counter. Random mode
//   triggers when the channel LFSR is below rate; periodic mode triggers
//   after rate+1 idle cycles.
//   Ports: clk, rst (async, active high), cfg_if (slave modport).

// One channel. SEED_CH is the already-fixed (non-zero) seed for this lane.
module multi_channel_pulse_source_ch #(
    parameter int              LFSR_W  = 16,
    parameter logic [LFSR_W-1:0] TAPS  = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED_CH = 16'hACE1,
    parameter int              PW_W    = 4,
    parameter int              DT_W    = 8,
    parameter int              CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena_i,
    input  logic              mode_i,
    input  logic [LFSR_W-1:0] rate_i,
    input  logic [PW_W-1:0]   pw_i,
    input  logic [DT_W-1:0]   dt_i,
    input  logic              seed_load_i,
    input  logic              cnt_clr_i,
    output logic              pulse_o,
    output logic [CNT_W-1:0]  cnt_o
);
    localparam int TMR_W = (PW_W > DT_W) ? PW_W : DT_W;

    typedef enum logic [1:0] {IDLE, HIGH, DEAD} state_t;

    state_t            state_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [LFSR_W-1:0] icnt_q;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [DT_W-1:0]   dt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              pulse_q;
    logic              trig;
    logic [TMR_W-1:0]  pw_eff;

    // Trigger uses the pre-advance LFSR value.
    assign trig   = (state_q == IDLE) && ena_i &&
                    (mode_i ? (icnt_q >= rate_i) : (lfsr_q < rate_i));
    assign pw_eff = (pw_i == '0) ? TMR_W'(1) : TMR_W'(pw_i);

    // Reload wins over advance; a non-zero seed keeps the LFSR off zero.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load_i)
            lfsr_d = SEED_CH;
        else if (ena_i)
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            icnt_q  <= '0;
            lfsr_q  <= SEED_CH;
            dt_q    <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_q <= HIGH;
                        pulse_q <= 1'b1;
                        tmr_q   <= pw_eff;
                        dt_q    <= dt_i;
                        icnt_q  <= '0;
                    end else if (ena_i && mode_i) begin
                        icnt_q  <= icnt_q + LFSR_W'(1);
                    end
                end
                HIGH: begin
                    if (tmr_q == TMR_W'(1)) begin
                        pulse_q <= 1'b0;
                        if (dt_q != '0) begin
                            state_q <= DEAD;
                            tmr_q   <= TMR_W'(dt_q);
                        end else begin
                            state_q <= IDLE;
                            tmr_q   <= '0;
                            icnt_q  <= '0;
                        end
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                DEAD: begin
                    if (tmr_q == TMR_W'(1)) begin
                        state_q <= IDLE;
                        tmr_q   <= '0;
                        icnt_q  <= '0;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pulse_q <= 1'b0;
                end
            endcase
            // Clear beats a coincident trigger.
            if (cnt_clr_i)
                cnt_q <= '0;
            else if (trig && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign pulse_o = pulse_q;
    assign cnt_o   = cnt_q;
endmodule

module multi_channel_pulse_source #(
    parameter int                N_CH   = 4,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
    parameter int                PW_W   = 4,
    parameter int                DT_W   = 8,
    parameter int                CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    multi_channel_pulse_source_if.slave  cfg_if
);
    logic [N_CH-1:0]            pulse_w;
    logic [N_CH-1:0][CNT_W-1:0] cnt_w;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [LFSR_W-1:0] SRAW = SEED ^ LFSR_W'(i);
        localparam logic [LFSR_W-1:0] SCH  = (SRAW == '0) ? LFSR_W'(1) : SRAW;

        multi_channel_pulse_source_ch #(
            .LFSR_W (LFSR_W),
            .TAPS   (TAPS),
            .SEED_CH(SCH),
            .PW_W   (PW_W),
            .DT_W   (DT_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .ena_i      (cfg_if.ena),
            .mode_i     (cfg_if.mode),
            .rate_i     (cfg_if.rate),
            .pw_i       (cfg_if.pulse_width),
            .dt_i       (cfg_if.dead_time),
            .seed_load_i(cfg_if.seed_load),
            .cnt_clr_i  (cfg_if.cnt_clr),
            .pulse_o    (pulse_w[i]),
            .cnt_o      (cnt_w[i])
        );
    end

    assign cfg_if.pulse     = pulse_w;
    assign cfg_if.evt_count = cnt_w;
endmodule
